// File: rtl/example_jjm469_accumulator.sv
// example_jjm469_accumulator: 8-bit registered accumulator/ALU tile.
// Operand on ui_in, opcode on uio_in[2:0], execute strobe on uio_in[3].
// ACC drives uo_out; Z/C/N/P flags drive uio_out[7:4].
// Optional macro JJM469_SAT_EN: ADD and SUB saturate instead of wrapping.
// Note: rst_n is active-high despite its name (clears state while 1).
module example_jjm469_accumulator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_ROL  = 3'b111
    } op_e;

    logic [7:0] acc_q, acc_d;
    logic       c_q, c_d;
    logic [8:0] sum_w;
    logic [8:0] diff_w;
    logic       exec_w;
    op_e        op_w;
    logic       unused_hi_bits;

    // High nibble of uio_in is deliberately ignored.
    assign unused_hi_bits = ^uio_in[7:4];

    assign op_w   = op_e'(uio_in[2:0]);
    assign exec_w = ena & uio_in[3];

    // Bit 8 of the difference is the borrow (set iff B > ACC).
    assign sum_w  = {1'b0, acc_q} + {1'b0, ui_in};
    assign diff_w = {1'b0, acc_q} - {1'b0, ui_in};

    // Next-state ALU: hold unless enabled and strobed.
    always_comb begin
        acc_d = acc_q;
        c_d   = c_q;
        if (exec_w) begin
            case (op_w)
                OP_NOP: begin
                    acc_d = acc_q;
                    c_d   = c_q;
                end
                OP_LOAD: begin
                    acc_d = ui_in;
                    c_d   = 1'b0;
                end
                OP_ADD: begin
`ifdef JJM469_SAT_EN
                    acc_d = sum_w[8] ? 8'hFF : sum_w[7:0];
                    c_d   = sum_w[8];
`else
                    acc_d = sum_w[7:0];
                    c_d   = sum_w[8];
`endif
                end
                OP_SUB: begin
`ifdef JJM469_SAT_EN
                    acc_d = diff_w[8] ? 8'h00 : diff_w[7:0];
                    c_d   = diff_w[8];
`else
                    acc_d = diff_w[7:0];
                    c_d   = diff_w[8];
`endif
                end
                OP_AND: begin
                    acc_d = acc_q & ui_in;
                    c_d   = 1'b0;
                end
                OP_OR: begin
                    acc_d = acc_q | ui_in;
                    c_d   = 1'b0;
                end
                OP_XOR: begin
                    acc_d = acc_q ^ ui_in;
                    c_d   = 1'b0;
                end
                OP_ROL: begin
                    acc_d = {acc_q[6:0], c_q};
                    c_d   = acc_q[7];
                end
                default: begin
                    acc_d = acc_q;
                    c_d   = c_q;
                end
            endcase
        end
    end

    // Accumulator and carry registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc_q <= '0;
            c_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            c_q   <= c_d;
        end
    end

    assign uo_out  = acc_q;
    assign uio_out = {^acc_q, acc_q[7], c_q, (acc_q == 8'h00), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_example_jjm469_accumulator.sv
// Directed self-checking bench for example_jjm469_accumulator.
module tb_example_jjm469_accumulator;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned checks;
    int unsigned failures;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] SUB  = 3'b011;
    localparam logic [2:0] XOR_ = 3'b110;
    localparam logic [2:0] ROL  = 3'b111;

    example_jjm469_accumulator dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // One strobed operation; inputs change 1 time unit after a rising edge.
    task automatic exec(input logic [2:0] op, input logic [7:0] b);
        uio_in = {4'hA, 1'b1, op};
        ui_in  = b;
        @(posedge clk);
        #1;
        uio_in = {4'h5, 1'b0, NOP};
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        // Reset held with junk inputs and an active strobe.
        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h5A;
        uio_in = {4'hF, 1'b1, ADD};
        #2;
        check("reset_acc_async", uo_out, 8'h00);
        idle(3);
        check("reset_acc", uo_out, 8'h00);
        check("reset_flags", uio_out, 8'h10);
        check("reset_oe", uio_oe, 8'hF0);
        rst_n  = 1'b0;
        uio_in = 8'h00;
        idle(5);
        check("idle_acc", uo_out, 8'h00);
        check("idle_flags", uio_out, 8'h10);

        // Load / add with carry out.
        exec(LOAD, 8'hF0);
        check("load_f0", uo_out, 8'hF0);
        check("load_f0_flags", uio_out, 8'h40);
        exec(ADD, 8'h20);
`ifdef JJM469_SAT_EN
        check("add_sat_acc", uo_out, 8'hFF);
        check("add_sat_flags", uio_out, 8'h60);
`else
        check("add_wrap_acc", uo_out, 8'h10);
        check("add_wrap_flags", uio_out, 8'hA0);
`endif

        // Subtract to zero, then borrow.
        exec(LOAD, 8'h05);
        exec(SUB, 8'h05);
        check("sub_zero_acc", uo_out, 8'h00);
        check("sub_zero_flags", uio_out, 8'h10);
        exec(SUB, 8'h01);
`ifdef JJM469_SAT_EN
        check("sub_sat_acc", uo_out, 8'h00);
        check("sub_sat_flags", uio_out, 8'h30);
`else
        check("sub_borrow_acc", uo_out, 8'hFF);
        check("sub_borrow_flags", uio_out, 8'h60);
`endif

        // Logic and rotate through carry.
        exec(LOAD, 8'h81);
        exec(XOR_, 8'hFF);
        check("xor_acc", uo_out, 8'h7E);
        check("xor_flags", uio_out, 8'h00);
        exec(ROL, 8'hFF);
        check("rol1_acc", uo_out, 8'hFC);
        check("rol1_flags", uio_out, 8'h40);
        exec(ROL, 8'h00);
        check("rol2_acc", uo_out, 8'hF8);
        check("rol2_flags", uio_out, 8'hE0);

        // Gating by ena and strobe.
        exec(LOAD, 8'h3C);
        ena = 1'b0;
        exec(ADD, 8'h01);
        ena = 1'b1;
        check("ena_gate", uo_out, 8'h3C);
        uio_in = {4'h0, 1'b0, ADD};
        ui_in  = 8'h01;
        idle(2);
        check("strobe_gate", uo_out, 8'h3C);
        check("gate_flags", uio_out, 8'h00);
        uio_in = {4'h0, 1'b1, ADD};
        idle(4);
        uio_in = 8'h00;
        check("burst4_acc", uo_out, 8'h40);
        check("burst4_flags", uio_out, 8'h80);

        // Asynchronous reset in the middle of an ADD burst.
        uio_in = {4'h0, 1'b1, ADD};
        idle(2);
        check("burst_pre_rst", uo_out, 8'h42);
        #3;
        rst_n = 1'b1;
        #1;
        check("async_rst_acc", uo_out, 8'h00);
        check("async_rst_flags", uio_out, 8'h10);
        @(posedge clk);
        #1;
        check("rst_hold_acc", uo_out, 8'h00);
        rst_n = 1'b0;
        idle(1);
        check("post_rst_exec", uo_out, 8'h01);
        check("post_rst_flags", uio_out, 8'h80);
        uio_in = 8'h00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
